// File: rtl/cap_pkg.sv
// Shared definitions for the capture trace buffer: state encoding,
// default geometry and capture word width.
package cap_pkg;

   localparam int CAP_W      = 32;
   localparam int DEPTH_DEF  = 64;
   localparam int ADDR_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      POST = 2'd2,
      DONE = 2'd3
   } cap_state_t;

endpackage

// File: rtl/cap_trace_ram.sv
// DEPTH x W register array: one synchronous write port and one read
// port with a registered output (1-cycle latency). The read register
// holds its value when no read is requested.
module cap_trace_ram
   import cap_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int W      = CAP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [W-1:0]      wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [W-1:0]      rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Storage write port.
   // NOTE: the array has no reset on purpose; resetting every entry would
   // turn it into a large bank of resettable flops for no functional gain.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; output word is reset so the block comes up clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cap_trace_buf.sv
// Circular trace buffer with arm / trigger / post-trigger capture and a
// chronological drain port. Control FSM, pointers and counters live here;
// storage is in cap_trace_ram.
module cap_trace_buf
   import cap_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CAP_W-1:0]  cap_data,
   input  logic              cap_data_vld,
   input  logic              cap_mode_vld,
   input  logic              arm,
   input  logic              trig,
   input  logic [ADDR_W-1:0] post_len,
   input  logic              clear,
   input  logic              rd_en,
   output logic [CAP_W-1:0]  rd_data,
   output logic              rd_data_vld,
   output logic              rd_empty,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] wr_ptr
);

   cap_state_t        state, state_n;
   logic              acc;        // sample accepted this cycle
   logic              start;      // arm taken: reset capture bookkeeping
   logic              trig_take;  // trigger taken in PRE
   logic              rd_fire;    // read request honoured
   logic              trig_pend;  // trigger seen but trigger sample not yet stored
   logic [ADDR_W-1:0] post_cnt;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   rd_avail;
   logic [ADDR_W-1:0] rd_ptr;

   // Read pointer is the oldest entry plus the number already drained.
   assign rd_avail = wrapped ? (ADDR_W+1)'(DEPTH) : {1'b0, wr_ptr};
   assign rd_ptr   = (wrapped ? wr_ptr : '0) + rd_cnt[ADDR_W-1:0];
   assign rd_empty = (state != DONE) || (rd_cnt == rd_avail);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and control decode; clear beats arm beats trig.
   // NOTE: every signal gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n   = state;
      start     = 1'b0;
      trig_take = 1'b0;
      acc       = cap_data_vld && cap_mode_vld && !clear &&
                  (state == PRE || state == POST);
      rd_fire   = (state == DONE) && rd_en && !rd_empty && !clear && !arm;
      if (clear) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (arm) begin
                  state_n = PRE;
                  start   = 1'b1;
               end
            end
            PRE: begin
               if (trig) begin
                  trig_take = 1'b1;
                  state_n   = (post_len == '0 && acc) ? DONE : POST;
               end
            end
            POST: begin
               if (acc && (trig_pend ? (post_cnt == '0) : (post_cnt == ADDR_W'(1))))
                  state_n = DONE;
            end
            DONE: begin
               if (arm) begin
                  state_n = PRE;
                  start   = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Status flags registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_n == PRE) || (state_n == POST);
         done <= (state_n == DONE);
      end
   end

   // Write pointer, wrap flag, trigger bookkeeping and drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         wrapped     <= 1'b0;
         trig_addr   <= '0;
         post_cnt    <= '0;
         trig_pend   <= 1'b0;
         rd_cnt      <= '0;
         rd_data_vld <= 1'b0;
      end else if (clear || start) begin
         wr_ptr      <= '0;
         wrapped     <= 1'b0;
         trig_addr   <= '0;
         post_cnt    <= '0;
         trig_pend   <= 1'b0;
         rd_cnt      <= '0;
         rd_data_vld <= 1'b0;
      end else begin
         rd_data_vld <= rd_fire;
         if (acc) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == ADDR_W'(DEPTH - 1)) wrapped <= 1'b1;
         end
         if (trig_take) begin
            trig_addr <= wr_ptr;
            post_cnt  <= post_len;
            trig_pend <= !acc;
         end else if (state == POST && acc) begin
            if (trig_pend) trig_pend <= 1'b0;
            else           post_cnt  <= post_cnt - ADDR_W'(1);
         end
         if (rd_fire) rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
      end
   end

   cap_trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .W      (CAP_W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (acc),
      .wr_addr (wr_ptr),
      .wr_data (cap_data),
      .rd_en   (rd_fire),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_cap_trace_buf.sv
// Bench for cap_trace_buf: scenario tasks drive captures, push expected
// drain words into a queue, and a monitor pops and compares each rd_data.
module tb_cap_trace_buf;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       cap_data;
   logic              cap_data_vld;
   logic              cap_mode_vld;
   logic              arm;
   logic              trig;
   logic [ADDR_W-1:0] post_len;
   logic              clear;
   logic              rd_en;
   logic [31:0]       rd_data;
   logic              rd_data_vld;
   logic              rd_empty;
   logic              busy;
   logic              done;
   logic              wrapped;
   logic [ADDR_W-1:0] trig_addr;
   logic [ADDR_W-1:0] wr_ptr;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];

   cap_trace_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cap_data     (cap_data),
      .cap_data_vld (cap_data_vld),
      .cap_mode_vld (cap_mode_vld),
      .arm          (arm),
      .trig         (trig),
      .post_len     (post_len),
      .clear        (clear),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_data_vld  (rd_data_vld),
      .rd_empty     (rd_empty),
      .busy         (busy),
      .done         (done),
      .wrapped      (wrapped),
      .trig_addr    (trig_addr),
      .wr_ptr       (wr_ptr)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every read word is checked against the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_data_vld !== 1'b0) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rd_unexpected: rd_data_vld=%b rd_data=%h, required no read", rd_data_vld, rd_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               fails++;
               $display("FAIL rd_data: got %h, required %h", rd_data, e);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic pulse_arm();
      arm = 1'b1; step(); arm = 1'b0;
   endtask

   task automatic feed(input logic [31:0] w, input logic t, input logic mode);
      cap_data = w; cap_data_vld = 1'b1; cap_mode_vld = mode; trig = t;
      step();
      cap_data_vld = 1'b0; cap_mode_vld = 1'b1; trig = 1'b0;
   endtask

   task automatic rd_one(input logic [31:0] e);
      exp_q.push_back(e);
      rd_en = 1'b1; step(); rd_en = 1'b0;
   endtask

   task automatic drain_end(input string name);
      step(); step();
      chk({name, "_all_read"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_rd_empty"}, 32'(rd_empty), 32'd1);
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cap_data = '0; cap_data_vld = 1'b0; cap_mode_vld = 1'b1;
      arm = 1'b0; trig = 1'b0; post_len = '0; clear = 1'b0; rd_en = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_rd_empty",  32'(rd_empty),    32'd1);
      chk("rst_done",      32'(done),        32'd0);
      chk("rst_busy",      32'(busy),        32'd0);
      chk("rst_wrapped",   32'(wrapped),     32'd0);
      chk("rst_wr_ptr",    32'(wr_ptr),      32'd0);
      chk("rst_trig_addr", 32'(trig_addr),   32'd0);
      chk("rst_rd_data",   rd_data,          32'd0);
      rd_en = 1'b1; step(); rd_en = 1'b0; step();
      chk("rst_rd_vld",    32'(rd_data_vld), 32'd0);
      chk("rst_rd_empty2", 32'(rd_empty),    32'd1);
   endtask

   task automatic test_basic();
      post_len = 6'd3;
      pulse_arm();
      chk("basic_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 10; i++) begin
         feed(32'h100 + 32'(i), i == 5, 1'b1);
         if (i == 7) chk("basic_not_done_yet", 32'(done), 32'd0);
         if (i == 8) chk("basic_done", 32'(done), 32'd1);
      end
      chk("basic_trig_addr", 32'(trig_addr), 32'd5);
      chk("basic_wrapped",   32'(wrapped),   32'd0);
      chk("basic_wr_ptr",    32'(wr_ptr),    32'd9);
      chk("basic_busy_off",  32'(busy),      32'd0);
      for (int i = 0; i < 9; i++) rd_one(32'h100 + 32'(i));
      drain_end("basic");
      rd_en = 1'b1; step(); rd_en = 1'b0; step();
      chk("basic_empty_rd_vld", 32'(rd_data_vld), 32'd0);
   endtask

   task automatic test_wrap();
      post_len = 6'd5;
      pulse_arm();
      chk("wrap_cleared", 32'(wrapped), 32'd0);
      for (int i = 0; i < 100; i++) begin
         feed(32'(i), i == 90, 1'b1);
         if (i == 94) chk("wrap_not_done_yet", 32'(done), 32'd0);
         if (i == 95) chk("wrap_done", 32'(done), 32'd1);
      end
      chk("wrap_wrapped",   32'(wrapped),   32'd1);
      chk("wrap_wr_ptr",    32'(wr_ptr),    32'd32);
      chk("wrap_trig_addr", 32'(trig_addr), 32'd26);
      for (int i = 0; i < 64; i++) rd_one(32'd32 + 32'(i));
      drain_end("wrap");
   endtask

   task automatic test_post_zero();
      post_len = 6'd0;
      pulse_arm();
      for (int i = 0; i < 3; i++) feed(32'h70 + 32'(i), 1'b0, 1'b1);
      feed(32'hDEAD, 1'b1, 1'b0);
      chk("pz_in_post_busy", 32'(busy),      32'd1);
      chk("pz_in_post_done", 32'(done),      32'd0);
      chk("pz_trig_addr",    32'(trig_addr), 32'd3);
      step();
      chk("pz_still_post",   32'(done),      32'd0);
      feed(32'hABCD, 1'b0, 1'b1);
      chk("pz_done",         32'(done),      32'd1);
      chk("pz_wr_ptr",       32'(wr_ptr),    32'd4);
      for (int i = 0; i < 3; i++) rd_one(32'h70 + 32'(i));
      rd_one(32'hABCD);
      drain_end("pz");
   endtask

   task automatic test_clear();
      post_len = 6'd10;
      pulse_arm();
      for (int i = 0; i < 5; i++) feed(32'h200 + 32'(i), i == 2, 1'b1);
      chk("clr_pre_busy", 32'(busy), 32'd1);
      clear = 1'b1; step(); clear = 1'b0;
      chk("clr_busy",      32'(busy),      32'd0);
      chk("clr_done",      32'(done),      32'd0);
      chk("clr_wrapped",   32'(wrapped),   32'd0);
      chk("clr_wr_ptr",    32'(wr_ptr),    32'd0);
      chk("clr_trig_addr", 32'(trig_addr), 32'd0);
      chk("clr_rd_empty",  32'(rd_empty),  32'd1);
      feed(32'h333, 1'b1, 1'b1);
      chk("idle_trig_busy",  32'(busy),   32'd0);
      chk("idle_trig_wrptr", 32'(wr_ptr), 32'd0);
      post_len = 6'd1;
      pulse_arm();
      feed(32'h50, 1'b1, 1'b1);
      feed(32'h51, 1'b0, 1'b1);
      chk("rearm_done",      32'(done),      32'd1);
      chk("rearm_trig_addr", 32'(trig_addr), 32'd0);
      rd_one(32'h50);
      rd_one(32'h51);
      drain_end("rearm");
   endtask

   task automatic test_back_to_back();
      clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
      chk("prio_busy", 32'(busy), 32'd0);
      chk("prio_done", 32'(done), 32'd0);
      post_len = 6'd0;
      pulse_arm();
      chk("b2b_busy", 32'(busy), 32'd1);
      feed(32'h11, 1'b0, 1'b1);
      rd_en = 1'b1; step(); rd_en = 1'b0; step();
      chk("pre_rd_vld", 32'(rd_data_vld), 32'd0);
      arm = 1'b1; step(); arm = 1'b0;
      chk("pre_arm_ignored", 32'(wr_ptr), 32'd1);
      feed(32'h22, 1'b1, 1'b1);
      chk("b2b_done", 32'(done), 32'd1);
      rd_one(32'h11);
      rd_one(32'h22);
      drain_end("b2b");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_post_zero();
      test_clear();
      test_back_to_back();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
